conversor_bin_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one input bit per clock. It sits directly upstream of the 7-segment display decoders. It takes the raw switch value and delivers registered units/tens/hundreds/thousands BCD digits with a start/done handshake. This replaces a wide combinational divide/modulo path with a small iterative datapath.

---
 rtl/conversor_bin_bcd_seq.sv | 109 ++++++++++
 tb/tb_conversor_bin_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_bin_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Produces four registered BCD digits with a start/busy/done handshake.
module conversor_bin_bcd_seq #(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] input_bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd_u,
    output logic [3:0]   bcd_d,
    output logic [3:0]   bcd_c,
    output logic [3:0]   bcd_m
);

    localparam int CNT_W = $clog2(N + 1);

    if (N < 1 || N > 13) begin : g_bad_n
        $error("conversor_bin_bcd_seq: N=%0d outside supported range 1..13", N);
    end
    if (DIGITS != 4 || (10 ** DIGITS) <= ((2 ** N) - 1)) begin : g_bad_digits
        $error("conversor_bin_bcd_seq: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, N);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       bin_sr_q, bin_sr_d;
    logic [15:0]        scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        bcd_q, bcd_d_w;
    logic [15:0]        adj;
    logic [N+15:0]      shifted;

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d_w   = bcd_q;
        adj       = scratch_q;

        // Digits are corrected independently; no carry crosses a digit boundary.
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = 4'(scratch_q[4*i +: 4] + 4'd3);
            end
        end
        shifted = {adj, bin_sr_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d  = input_bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(N);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[N+15:N];
                bin_sr_d  = shifted[N-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Result is published on the same edge that enters DONE.
                    bcd_d_w = shifted[N+15:N];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_sr_q  <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_sr_q  <= bin_sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d_w;
        end
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign bcd_m = bcd_q[15:12];
    assign bcd_c = bcd_q[11:8];
    assign bcd_d = bcd_q[7:4];
    assign bcd_u = bcd_q[3:0];

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Directed and randomized checks of conversor_bin_bcd_seq against a decimal-arithmetic model.
module tb_conversor_bin_bcd_seq;

    localparam int N = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] input_bin;
    logic         busy;
    logic         done;
    logic [3:0]   bcd_u, bcd_d, bcd_c, bcd_m;

    int tests;
    int failed;
    int done_cnt;
    int viol;
    logic prev_done_m;

    conversor_bin_bcd_seq #(.N(N), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .input_bin (input_bin),
        .busy      (busy),
        .done      (done),
        .bcd_u     (bcd_u),
        .bcd_d     (bcd_d),
        .bcd_c     (bcd_c),
        .bcd_m     (bcd_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: busy/done exclusivity, single-cycle done, done pulse count.
    always @(negedge clk) begin
        if (busy && done) viol <= viol + 1;
        if (done && prev_done_m) viol <= viol + 1;
        prev_done_m <= done;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] dut_bcd();
        return {bcd_m, bcd_c, bcd_d, bcd_u};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents start for one edge; lat counts edges with the accepting edge as 1.
    task automatic do_conv(input int v, output int lat, output logic busy1);
        @(negedge clk);
        input_bin = N'(v);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int         lat;
    logic       b1;
    int         d0;
    int         vals[6];
    int         q[$];
    int         cur;
    int         ndone;
    int         cyc;
    int         last_done;
    logic       prev_busy;
    logic [15:0] exp_v;

    initial begin
        tests = 0; failed = 0; done_cnt = 0; viol = 0; prev_done_m = 1'b0;

        // Reset held with start asserted: nothing may begin.
        rst_n = 1'b0; start = 1'b1; input_bin = 10'd1023;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_digits", 32'(dut_bcd()), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);

        do_conv(0, lat, b1);
        chk("busy_after_accept", 32'(b1), 32'd1);
        chk("lat_0", 32'(lat), 32'd11);
        chk("dig_0", 32'(dut_bcd()), 32'(ref_bcd(0)));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        do_conv(1023, lat, b1);
        chk("lat_1023", 32'(lat), 32'd11);
        chk("dig_1023", 32'(dut_bcd()), 32'h1023);

        vals = '{999, 1000, 9, 10, 0, 0};
        for (int i = 0; i < 4; i++) begin
            do_conv(vals[i], lat, b1);
            chk($sformatf("lat_%0d", vals[i]), 32'(lat), 32'd11);
            chk($sformatf("dig_%0d", vals[i]), 32'(dut_bcd()), 32'(ref_bcd(vals[i])));
        end

        // Start and input changes during busy must be ignored.
        repeat (3) @(negedge clk);
        #1 d0 = done_cnt;
        @(negedge clk);
        input_bin = 10'd512; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        input_bin = 10'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; input_bin = 10'd300;
        repeat (30) @(negedge clk);
        #1;
        chk("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
        chk("ignored_start_result", 32'(dut_bcd()), 32'h0512);

        // Reset in the middle of SHIFT aborts and clears outputs.
        #1 d0 = done_cnt;
        @(negedge clk);
        input_bin = 10'd777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", 32'(dut_bcd()), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_digits_hold", 32'(dut_bcd()), 32'd0);
        do_conv(777, lat, b1);
        chk("lat_777", 32'(lat), 32'd11);
        chk("dig_777", 32'(dut_bcd()), 32'h0777);

        // Continuous start with random values, one new value per acceptance.
        @(negedge clk);
        cur = int'($urandom_range(1023));
        input_bin = N'(cur);
        start = 1'b1;
        prev_busy = 1'b0;
        ndone = 0; cyc = 0; last_done = -1;
        while (ndone < 200 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                q.push_back(cur);
                cur = int'($urandom_range(1023));
                input_bin = N'(cur);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_v = ref_bcd(q.pop_front());
                    chk($sformatf("rand_result_%0d", ndone), 32'(dut_bcd()), 32'(exp_v));
                end
                if (last_done >= 0)
                    chk($sformatf("rand_period_%0d", ndone), 32'(cyc - last_done), 32'd12);
                last_done = cyc;
                ndone++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("rand_all_done", 32'(ndone), 32'd200);
        repeat (15) @(negedge clk);
        #1;
        chk("busy_done_protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
